uart_program_loader: RTL and testbench
======================================

# uart_program_loader

Serial boot loader for the multicycle RV32I core. It receives a framed program image over a UART RX line and writes it word-by-word into the unified memory's write port. While a load is in progress it holds the core in reset, and it releases the core once the frame checksum verifies. It sits beside `top`'s memory instance: it drives the memory write port and the core-hold signal, and the core owns the port only when `cpu_hold` is low.

## Interface
- `CLK_FREQ`, 12_000_000: system clock frequency in Hz.
- `BAUD`, 115200: UART bit rate; `CLKS_PER_BIT = CLK_FREQ / BAUD` (104 at defaults), integer-truncated.
- `BASE_ADDR`, 32'h0000_0000: byte address of the first loaded word.
- `MAX_WORDS`, 2048: maximum accepted word count; larger counts are an error.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous UART receive line, idle high, 8N1, LSB first.
- `mem_write_en`  out  1  one-cycle write strobe to memory.
- `mem_write_address`  out  32  byte address of the current write, word aligned.
- `mem_write_data`  out  32  assembled little-endian word.
- `mem_funct3`  out  3  width code for the write; constant 3'b010 (word).
- `cpu_hold`  out  1  high while the core must stay in reset and off the memory port.
- `load_done`  out  1  high after a verified load, until the next frame starts or reset.
- `load_error`  out  1  high after a failed frame, until the next frame starts or reset.

## Operation
- **Frame format:** SYNC 0xA5, then LEN_LO, LEN_HI (word count N, little-endian), then 4·N data bytes (each word little-endian), then CHK. CHK equals the XOR of LEN_LO, LEN_HI and all data bytes.
- **Receiver:**
  - `rx` passes through a 2-flop synchronizer.
  - A falling edge starts reception. The line is re-checked at CLKS_PER_BIT/2; if it is high there, the start is treated as a glitch and the receiver returns to idle.
  - Each data bit and the stop bit are sampled every CLKS_PER_BIT after that check.
  - A stop bit of 0 is a framing error: the byte is discarded and the `frame_err` pulse is raised.
  - A good byte raises the one-cycle `byte_valid` pulse together with the byte.
- **Loader FSM states:** IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR. Reset enters IDLE.
  - IDLE: bytes other than 0xA5 are ignored; 0xA5 goes to LEN_LO, clears the checksum, and sets the address to BASE_ADDR.
  - LEN_LO → LEN_HI on each byte. Each length byte is XORed into the checksum.
  - LEN_HI: if N > MAX_WORDS, go to ERROR; if N == 0, go to CHECK; otherwise go to DATA.
  - DATA: shift bytes into a 32-bit register (byte k → bits [8k+7:8k]), XORing each into the checksum.
    - On the 4th byte, assert `mem_write_en` with the word and the current address.
    - After that strobe, add 4 to the address and decrement the remaining count.
    - When the count reaches 0, go to CHECK.
  - CHECK: the next byte equal to the checksum goes to DONE; any other value goes to ERROR.
  - DONE and ERROR: a 0xA5 byte restarts the frame exactly as in IDLE and clears `load_done`/`load_error`. Other bytes are ignored.
  - A receiver framing error in any state other than IDLE/DONE/ERROR goes to ERROR.
- **`cpu_hold`:** high in every state except DONE.
- **Arithmetic:** the address is 32-bit and wraps modulo 2^32; no overflow check. The count is 16-bit.

## Timing
- **Reset values:**
  - `cpu_hold`=1, `mem_funct3`=3'b010.
  - All other outputs 0.
  - FSM in IDLE, receiver idle, checksum 0, address BASE_ADDR.
- **Reset mid-byte or mid-frame:** the partial byte and the frame are abandoned; nothing further is written.
- **Byte latency:** `byte_valid` rises 1 cycle after the stop-bit sample (about 9.5 bit times after the start edge, plus 2 synchronizer cycles).
- **Write latency:** `mem_write_en` rises 1 cycle after the `byte_valid` of the 4th byte and stays high for exactly 1 cycle. Address and data are stable during the strobe.
- **Status latency:** `load_done`/`load_error` and `cpu_hold` update 1 cycle after the CHK byte's `byte_valid`.
- **Write spacing:** at least 4 byte times (about 40·CLKS_PER_BIT cycles) between writes; no back-pressure is needed.

## Structure
- `loader_pkg`: the FSM state enum, `SYNC_BYTE = 8'hA5`, `FUNCT3_WORD = 3'b010`.
- Sub-module `uart_rx`, parameterised by CLKS_PER_BIT. It contains the synchronizer, baud counter and bit FSM, and its outputs are `byte_valid`, `byte_data[7:0]` and `frame_err`.
- The top level adds a 2:1 mux in front of the memory write port selected by `cpu_hold`, and drives the core's reset from `reset | cpu_hold`.

## Test plan
- **Normal 2-word load:** send A5 02 00 13 00 00 00 6F 00 00 00 7E → writes 0x00000013 @0x0 then 0x0000006F @0x4. Then `load_done`=1 and `cpu_hold`=0.
- **Bad checksum:** same frame with CHK=0x7F → both writes occur, `load_error`=1, `cpu_hold` stays 1. A following valid frame clears `load_error` and ends in DONE.
- **Zero-length frame and oversize count:**
  - A5 00 00 00 → no writes, `load_done`=1.
  - A5 01 08 (N=2049) → ERROR with no writes.
- **Idle noise and glitches:**
  - Bytes 00 FF 5A before A5 are ignored.
  - A 0.3-bit low glitch on `rx` produces no `byte_valid`.
- **Framing error:** a stop bit of 0 in the DATA state → ERROR, no write for the partial word.
- **Reset mid-frame:** assert `reset` after 2 data bytes → outputs return to their reset values, no write occurs. A fresh full frame then loads correctly starting at BASE_ADDR.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } load_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_VALID,
    RX_FERR
  } rx_state_t;

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam logic [2:0] FUNCT3_WORD = 3'b010;

endpackage

// File: rtl/uart_program_loader_if.sv
// Memory write port as seen by the loader, plus the core-side port it muxes in.
interface uart_program_loader_if;

  logic        mem_write_en;
  logic [31:0] mem_write_address;
  logic [31:0] mem_write_data;
  logic [2:0]  mem_funct3;

  logic        core_write_en;
  logic [31:0] core_write_address;
  logic [31:0] core_write_data;
  logic [2:0]  core_funct3;
  logic        core_reset;

  modport master (
    output mem_write_en, mem_write_address, mem_write_data, mem_funct3, core_reset,
    input  core_write_en, core_write_address, core_write_data, core_funct3
  );

  modport slave (
    input  mem_write_en, mem_write_address, mem_write_data, mem_funct3, core_reset,
    output core_write_en, core_write_address, core_write_data, core_funct3
  );

endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, start-glitch rejection.
module uart_rx
  import loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int unsigned CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST      = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_t     state, next;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          rx_meta, rx_sync, rx_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      state   <= next;
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      cnt     <= (state == RX_IDLE || state != next || cnt == LAST) ? '0 : cnt + 1'b1;
      if (state == RX_START) bit_idx <= '0;
      if (state == RX_DATA && cnt == LAST) begin
        shreg   <= {rx_sync, shreg[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

  always_comb begin
    next = state;
    case (state)
      RX_IDLE:  if (!rx_sync && rx_prev) next = RX_START;
      RX_START: if (cnt == HALF_LAST) next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (cnt == LAST && bit_idx == 3'd7) next = RX_STOP;
      RX_STOP:  if (cnt == LAST) next = rx_sync ? RX_VALID : RX_FERR;
      default:  next = RX_IDLE;
    endcase
  end

  always_comb begin
    byte_valid = (state == RX_VALID);
    frame_err  = (state == RX_FERR);
    byte_data  = shreg;
  end

endmodule

// File: rtl/uart_program_loader.sv
// Serial boot loader: receives a framed image over UART, writes it to memory, holds the core until verified.
module uart_program_loader
  import loader_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 12_000_000,
  parameter int unsigned BAUD      = 115200,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 2048
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  uart_program_loader_if.master mem,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_error
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;

  load_state_t state, next;
  logic        byte_valid, frame_err;
  logic [7:0]  byte_data;
  logic [7:0]  chk, len_lo;
  logic [15:0] count;
  logic [31:0] addr, word;
  logic [1:0]  byte_idx;
  logic        we_q;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      chk      <= '0;
      len_lo   <= '0;
      count    <= '0;
      addr     <= BASE_ADDR;
      word     <= '0;
      byte_idx <= '0;
      we_q     <= 1'b0;
    end else begin
      state <= next;
      // Strobe is registered off the 4th byte; address/count advance as it retires.
      we_q  <= (state == ST_DATA) && byte_valid && (byte_idx == 2'd3);
      if (we_q) begin
        addr  <= addr + 32'd4;
        count <= count - 16'd1;
      end
      if (byte_valid) begin
        case (state)
          ST_IDLE, ST_DONE, ST_ERROR: begin
            if (byte_data == SYNC_BYTE) begin
              chk      <= '0;
              addr     <= BASE_ADDR;
              byte_idx <= '0;
            end
          end
          ST_LEN_LO: begin
            len_lo <= byte_data;
            chk    <= chk ^ byte_data;
          end
          ST_LEN_HI: begin
            count <= {byte_data, len_lo};
            chk   <= chk ^ byte_data;
          end
          ST_DATA: begin
            word     <= {byte_data, word[31:8]};
            byte_idx <= byte_idx + 2'd1;
            chk      <= chk ^ byte_data;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    next = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR:
        if (byte_valid && byte_data == SYNC_BYTE) next = ST_LEN_LO;
      ST_LEN_LO:
        if (byte_valid) next = ST_LEN_HI;
      ST_LEN_HI:
        if (byte_valid) begin
          if (32'({byte_data, len_lo}) > MAX_WORDS) next = ST_ERROR;
          else if ({byte_data, len_lo} == 16'd0)   next = ST_CHECK;
          else                                     next = ST_DATA;
        end
      ST_DATA:
        if (byte_valid && byte_idx == 2'd3 && count == 16'd1) next = ST_CHECK;
      ST_CHECK:
        if (byte_valid) next = (byte_data == chk) ? ST_DONE : ST_ERROR;
      default: next = ST_IDLE;
    endcase
    if (frame_err && (state == ST_LEN_LO || state == ST_LEN_HI ||
                      state == ST_DATA   || state == ST_CHECK))
      next = ST_ERROR;
  end

  always_comb begin
    cpu_hold   = (state != ST_DONE);
    load_done  = (state == ST_DONE);
    load_error = (state == ST_ERROR);
    mem.core_reset        = reset | cpu_hold;
    mem.mem_write_en      = cpu_hold ? we_q        : mem.core_write_en;
    mem.mem_write_address = cpu_hold ? addr        : mem.core_write_address;
    mem.mem_write_data    = cpu_hold ? word        : mem.core_write_data;
    mem.mem_funct3        = cpu_hold ? FUNCT3_WORD : mem.core_funct3;
  end

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader: frames driven bit-by-bit on rx, writes logged from the memory port.
module tb_uart_program_loader;

  localparam int unsigned CPB = 16;

  logic clk = 1'b0;
  logic reset;
  logic rx;
  logic cpu_hold, load_done, load_error;

  uart_program_loader_if bus ();

  uart_program_loader #(
    .CLK_FREQ  (160),
    .BAUD      (10),
    .BASE_ADDR (32'h0000_0000),
    .MAX_WORDS (2048)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .mem        (bus),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_error (load_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int bv_count = 0;
  int f3_bad = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  always @(negedge clk) begin
    if (bus.mem_write_en && cpu_hold) begin
      wr_addr.push_back(bus.mem_write_address);
      wr_data.push_back(bus.mem_write_data);
      if (bus.mem_funct3 !== 3'b010) f3_bad++;
    end
    if (dut.byte_valid) bv_count++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_ok);
    if (!stop_ok) send_bit(1'b1);
  endtask

  task automatic sb(input logic [7:0] b);
    send_byte(b, 1'b1);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic two_word_frame(input logic [7:0] chk);
    sb(8'hA5); sb(8'h02); sb(8'h00);
    sb(8'h13); sb(8'h00); sb(8'h00); sb(8'h00);
    sb(8'h6F); sb(8'h00); sb(8'h00); sb(8'h00);
    sb(chk);
    idle_bits(2);
  endtask

  initial begin
    rx = 1'b1;
    reset = 1'b1;
    bus.core_write_en      = 1'b0;
    bus.core_write_address = '0;
    bus.core_write_data    = '0;
    bus.core_funct3        = 3'b000;
    repeat (5) @(negedge clk);

    check("rst_cpu_hold", cpu_hold, 1);
    check("rst_load_done", load_done, 0);
    check("rst_load_error", load_error, 0);
    check("rst_we", bus.mem_write_en, 0);
    check("rst_addr", bus.mem_write_address, 32'h0);
    check("rst_data", bus.mem_write_data, 32'h0);
    check("rst_funct3", bus.mem_funct3, 3'b010);
    check("rst_core_reset", bus.core_reset, 1);

    reset = 1'b0;
    idle_bits(2);

    // Idle noise then a 0.3-bit glitch
    bv_count = 0;
    sb(8'h00); sb(8'hFF); sb(8'h5A);
    idle_bits(1);
    rx = 1'b0;
    repeat (5) @(negedge clk);
    idle_bits(2);
    check("noise_byte_count", bv_count, 3);
    check("noise_writes", wr_addr.size(), 0);
    check("noise_hold", cpu_hold, 1);
    check("noise_state_idle", {load_done, load_error}, 2'b00);

    // Normal 2-word load
    clear_log();
    two_word_frame(8'h7E);
    check("norm_nwrites", wr_addr.size(), 2);
    check("norm_addr0", wr_addr[0], 32'h0000_0000);
    check("norm_data0", wr_data[0], 32'h0000_0013);
    check("norm_addr1", wr_addr[1], 32'h0000_0004);
    check("norm_data1", wr_data[1], 32'h0000_006F);
    check("norm_done", load_done, 1);
    check("norm_error", load_error, 0);
    check("norm_hold", cpu_hold, 0);
    check("norm_core_reset", bus.core_reset, 0);
    check("funct3_on_writes", f3_bad, 0);

    // Core owns the port once released
    bus.core_write_en      = 1'b1;
    bus.core_write_address = 32'h0000_0100;
    bus.core_write_data    = 32'h0000_0055;
    #1;
    check("mux_we", bus.mem_write_en, 1);
    check("mux_addr", bus.mem_write_address, 32'h0000_0100);
    check("mux_data", bus.mem_write_data, 32'h0000_0055);
    check("mux_funct3", bus.mem_funct3, 3'b000);
    bus.core_write_en = 1'b0;
    @(negedge clk);

    // Bad checksum, then a good frame recovers
    clear_log();
    two_word_frame(8'h7F);
    check("badchk_nwrites", wr_addr.size(), 2);
    check("badchk_data1", wr_data[1], 32'h0000_006F);
    check("badchk_error", load_error, 1);
    check("badchk_done", load_done, 0);
    check("badchk_hold", cpu_hold, 1);
    clear_log();
    sb(8'hA5);
    idle_bits(1);
    check("restart_clears_error", load_error, 0);
    sb(8'h02); sb(8'h00);
    sb(8'h13); sb(8'h00); sb(8'h00); sb(8'h00);
    sb(8'h6F); sb(8'h00); sb(8'h00); sb(8'h00);
    sb(8'h7E);
    idle_bits(2);
    check("recover_done", load_done, 1);
    check("recover_error", load_error, 0);
    check("recover_nwrites", wr_addr.size(), 2);

    // Zero-length frame
    clear_log();
    sb(8'hA5);
    idle_bits(1);
    check("zero_restart_clears_done", load_done, 0);
    check("zero_restart_hold", cpu_hold, 1);
    sb(8'h00); sb(8'h00); sb(8'h00);
    idle_bits(2);
    check("zero_done", load_done, 1);
    check("zero_nwrites", wr_addr.size(), 0);

    // Oversize count (2049)
    clear_log();
    sb(8'hA5); sb(8'h01); sb(8'h08);
    idle_bits(2);
    check("oversize_error", load_error, 1);
    check("oversize_hold", cpu_hold, 1);
    sb(8'h11); sb(8'h22); sb(8'h33); sb(8'h44);
    idle_bits(2);
    check("oversize_nwrites", wr_addr.size(), 0);

    // Framing error inside a partial word
    clear_log();
    sb(8'hA5); sb(8'h01); sb(8'h00); sb(8'h11); sb(8'h22);
    send_byte(8'h33, 1'b0);
    idle_bits(2);
    check("ferr_error", load_error, 1);
    check("ferr_nwrites", wr_addr.size(), 0);

    // Reset after two data bytes
    clear_log();
    sb(8'hA5); sb(8'h02); sb(8'h00); sb(8'h13); sb(8'h00);
    idle_bits(1);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_hold", cpu_hold, 1);
    check("midrst_status", {load_done, load_error}, 2'b00);
    check("midrst_addr", bus.mem_write_address, 32'h0);
    check("midrst_we", bus.mem_write_en, 0);
    reset = 1'b0;
    idle_bits(2);
    sb(8'h00); sb(8'h00);
    idle_bits(2);
    check("midrst_nwrites", wr_addr.size(), 0);
    check("midrst_still_idle", {load_done, load_error}, 2'b00);

    // Fresh frame after reset: one word 0xDEADBEEF, CHK = 01^EF^BE^AD^DE = 23
    sb(8'hA5); sb(8'h01); sb(8'h00);
    sb(8'hEF); sb(8'hBE); sb(8'hAD); sb(8'hDE);
    sb(8'h23);
    idle_bits(2);
    check("fresh_nwrites", wr_addr.size(), 1);
    check("fresh_addr", wr_addr[0], 32'h0000_0000);
    check("fresh_data", wr_data[0], 32'hDEAD_BEEF);
    check("fresh_done", load_done, 1);
    check("fresh_hold", cpu_hold, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
